// File: rtl/fyp_rx_monitor.sv
// fyp_rx_monitor
// Receive-side frame monitor. It consumes every beat the MAC offers and checks
// framing, length and error flags. It keeps saturating statistics counters
// for good frames, good-frame bytes and bad frames or framing events.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | between frames; a beat without sop here is stray
// IN_FRAME | sop accepted, accumulating length/error until eop
module fyp_rx_monitor #(
    parameter int unsigned MIN_BYTES = 60,
    parameter int unsigned MAX_BYTES = 1514,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      eth_ast_rx_data,
    input  logic             eth_ast_rx_sop,
    input  logic             eth_ast_rx_eop,
    input  logic [1:0]       eth_ast_rx_empty,
    input  logic [5:0]       eth_ast_rx_err,
    input  logic             eth_ast_rx_valid,
    output logic             eth_ast_rx_rdy,
    input  logic             stat_clear,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] byte_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [15:0]      last_len,
    output logic             frame_done,
    output logic             framing_err
);

    typedef enum logic {IDLE = 1'b0, IN_FRAME = 1'b1} state_t;

    // Byte sum is wide enough for both the counter and a saturated 16-bit length.
    localparam int unsigned    SW      = (CNT_W > 16) ? CNT_W + 1 : 17;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_q, state_d;
    logic               rdy_q;
    logic [15:0]        len_q, len_d;
    logic               err_flag_q, err_flag_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [15:0]        last_len_q, last_len_d;
    logic               frame_done_q, frame_done_d;
    logic               framing_err_q, framing_err_d;

    logic               accept;
    logic               stray, abort, start, cont, complete, frame_bad;
    logic [2:0]         beat_len;
    logic [16:0]        len_sum;
    logic [1:0]         err_inc;
    logic [SW-1:0]      byte_sum;
    logic [CNT_W+1:0]   err_sum;

    // Payload contents are never inspected; only framing matters here.
    logic               unused_data;
    assign unused_data = ^eth_ast_rx_data;

    assign accept = eth_ast_rx_valid && rdy_q;

    // State register; reset mid-frame drops the partial frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state: any sop restarts a frame, eop in a frame closes it.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (eth_ast_rx_sop)                             state_d = eth_ast_rx_eop ? IDLE : IN_FRAME;
            else if (state_q == IN_FRAME && eth_ast_rx_eop) state_d = IDLE;
        end
    end

    // Output decode: classify the accepted beat and build the frame's running length/error.
    always_comb begin
        beat_len   = eth_ast_rx_eop ? 3'(3'd4 - {1'b0, eth_ast_rx_empty}) : 3'd4;
        len_sum    = {1'b0, len_q} + 17'(beat_len);
        start      = accept && eth_ast_rx_sop;
        cont       = accept && !eth_ast_rx_sop && (state_q == IN_FRAME);
        stray      = accept && !eth_ast_rx_sop && (state_q == IDLE);
        abort      = start && (state_q == IN_FRAME);
        complete   = (start || cont) && eth_ast_rx_eop;

        len_d      = len_q;
        err_flag_d = err_flag_q;
        if (start) begin
            len_d      = 16'(beat_len);
            err_flag_d = |eth_ast_rx_err;
        end else if (cont) begin
            // Saturate so an oversized frame can never wrap back into the legal range.
            len_d      = len_sum[16] ? 16'hFFFF : len_sum[15:0];
            err_flag_d = err_flag_q | (|eth_ast_rx_err);
        end

        frame_bad     = err_flag_d || (len_d < 16'(MIN_BYTES)) || (len_d > 16'(MAX_BYTES));
        frame_done_d  = complete;
        framing_err_d = stray || abort;
        // An abort and a bad single-beat frame on the same beat cost two errors.
        err_inc       = 2'(stray || abort) + 2'(complete && frame_bad);
    end

    // Statistics next-state with saturation; clear overrides any same-cycle update.
    always_comb begin
        byte_sum    = SW'(byte_cnt_q) + SW'(len_d);
        err_sum     = {2'b00, err_cnt_q} + (CNT_W + 2)'(err_inc);

        frame_cnt_d = frame_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        err_cnt_d   = (err_sum > {2'b00, CNT_MAX}) ? CNT_MAX : err_sum[CNT_W-1:0];
        last_len_d  = complete ? len_d : last_len_q;

        if (complete && !frame_bad) begin
            if (frame_cnt_q != CNT_MAX) frame_cnt_d = frame_cnt_q + CNT_W'(1);
            byte_cnt_d = (byte_sum > SW'(CNT_MAX)) ? CNT_MAX : byte_sum[CNT_W-1:0];
        end

        if (stat_clear) begin
            frame_cnt_d = '0;
            byte_cnt_d  = '0;
            err_cnt_d   = '0;
            last_len_d  = '0;
        end
    end

    // Datapath and output registers; ready rises on the first edge out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdy_q         <= 1'b0;
            len_q         <= '0;
            err_flag_q    <= 1'b0;
            frame_cnt_q   <= '0;
            byte_cnt_q    <= '0;
            err_cnt_q     <= '0;
            last_len_q    <= '0;
            frame_done_q  <= 1'b0;
            framing_err_q <= 1'b0;
        end else begin
            rdy_q         <= 1'b1;
            len_q         <= len_d;
            err_flag_q    <= err_flag_d;
            frame_cnt_q   <= frame_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            err_cnt_q     <= err_cnt_d;
            last_len_q    <= last_len_d;
            frame_done_q  <= frame_done_d;
            framing_err_q <= framing_err_d;
        end
    end

    assign eth_ast_rx_rdy = rdy_q;
    assign frame_cnt      = frame_cnt_q;
    assign byte_cnt       = byte_cnt_q;
    assign err_cnt        = err_cnt_q;
    assign last_len       = last_len_q;
    assign frame_done     = frame_done_q;
    assign framing_err    = framing_err_q;

endmodule

// File: doc/fyp_rx_monitor.md
# fyp_rx_monitor

Receive-side frame monitor for the Ethernet packet generator. It sits downstream of the MAC's receive Avalon-ST interface and consumes every frame the MAC delivers, including generator traffic returned over loopback. It checks framing, length and error flags, and accumulates good-frame, byte and error statistics for the control/readout logic. It never back-pressures the MAC beyond reset.

## Interface
- MIN_BYTES, 60: smallest legal frame length in bytes (CRC stripped by MAC).
- MAX_BYTES, 1514: largest legal frame length in bytes.
- CNT_W, 32: width of the statistics counters.

- clk  in  1  single clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- eth_ast_rx_data  in  32  beat data; byte 0 in [31:24]; not inspected beyond framing.
- eth_ast_rx_sop  in  1  first beat of frame.
- eth_ast_rx_eop  in  1  last beat of frame.
- eth_ast_rx_empty  in  2  unused bytes in eop beat; ignored when eop=0.
- eth_ast_rx_err  in  6  MAC error flags; any bit set on any beat marks frame bad.
- eth_ast_rx_valid  in  1  beat valid.
- eth_ast_rx_rdy  out  1  monitor ready.
- stat_clear  in  1  synchronous clear of counters and last_len.
- frame_cnt  out  CNT_W  good frames received.
- byte_cnt  out  CNT_W  bytes in good frames.
- err_cnt  out  CNT_W  bad frames plus framing events.
- last_len  out  16  length of most recently completed frame.
- frame_done  out  1  one-cycle pulse per completed frame.
- framing_err  out  1  one-cycle pulse per framing event.

## Operation
- A beat is accepted when eth_ast_rx_valid && eth_ast_rx_rdy. Beats with valid=0 are ignored completely.
- eth_ast_rx_rdy is a register: 0 in reset, 1 from the first clk edge after reset_n deasserts, and 1 thereafter.
- The state machine has two states, IDLE and IN_FRAME. Reset state is IDLE.
- IDLE, accepted sop=1, eop=1: single-beat frame completes; len = 4 − empty; state stays IDLE.
- IDLE, accepted sop=1, eop=0: len = 4, err flag = |err; go to IN_FRAME.
- IDLE, accepted sop=0: stray beat. framing_err pulses, err_cnt increments, beat is discarded, state stays IDLE. Applies per stray beat.
- IN_FRAME, accepted sop=0, eop=0: len += 4; err flag |= |err.
- IN_FRAME, accepted eop=1, sop=0: len += 4 − empty; frame completes; go to IDLE.
- IN_FRAME, accepted sop=1: the current frame is aborted. framing_err pulses, err_cnt increments, and a new frame starts with that beat exactly as in IDLE; an abort plus a single-beat frame in the same beat counts both.
- Completion: the frame is bad if err flag=1, len < MIN_BYTES, or len > MAX_BYTES.
  - Good frame: frame_cnt += 1, byte_cnt += len.
  - Bad frame: err_cnt += 1.
  - In both cases last_len <= len and frame_done pulses.
- The len accumulator is 16 bits and saturates at 0xFFFF, so it can never wrap to look legal.
- All counters saturate at all-ones and never wrap.
- Where one beat requires err_cnt += 2 (abort plus bad single-beat frame), saturation applies to the sum.
- stat_clear=1 zeroes frame_cnt, byte_cnt, err_cnt and last_len on the next edge.
  - Clear takes priority over any same-cycle update.
  - frame_done and framing_err still pulse.
  - State and len are unaffected.
- Reset mid-frame returns to IDLE and discards the partial frame. Any continuation beats after reset count as stray.

## Timing
- Reset values: eth_ast_rx_rdy=0, all counters 0, last_len=0, frame_done=0, framing_err=0, state IDLE.
- Latency: counters, last_len, frame_done and framing_err update on the clk edge that accepts the triggering beat. They are visible in the following cycle, one cycle after the beat is presented.
- Throughput: one beat per cycle sustained. Back-to-back frames (eop then sop in the next cycle) run without bubbles.
- No combinational path exists from any input to any output.

## Test plan
- 64-byte frame as 16 beats, empty=0, err=0 -> frame_cnt=1, byte_cnt=64, last_len=64, err_cnt=0, one frame_done pulse the cycle after eop.
- 61-byte frame (16 beats, empty=3) followed back-to-back by a 1514-byte frame (379 beats, empty=2) -> frame_cnt=2, byte_cnt=1575, last_len=1514.
- 40-byte frame; then 64-byte frame with err=6'h02 on eop -> err_cnt=2, frame_cnt=0, last_len=64.
- Stray beat (sop=0) in IDLE, then sop mid-frame aborting a 5-beat partial, then a good 64-byte frame -> err_cnt=2, framing_err pulses twice, frame_cnt=1, byte_cnt=64.
- reset_n low for 1 cycle during beat 8 of 16, remaining 8 beats delivered -> rdy=0 during reset, err_cnt=8 (stray beats), frame_cnt=0.
- frame_cnt preloaded to all-ones via 2^CNT_W−1 frames (CNT_W=4 build), one more good frame -> frame_cnt stays 15; stat_clear coincident with eop -> counters 0, frame_done still pulses.
